// File: rtl/rca_seq_pkg.sv
// Purpose : shared types and constants for the sequential ripple-carry adder controller.
// Latency : n/a (package only).
// Backpressure : n/a.
// Contents: FSM state encoding, chunk width, index-width helper.
package rca_seq_pkg;

   localparam int CHUNK_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Width of the chunk index counter; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rca3.sv
// Purpose : 3-bit ripple-carry adder made of three full adders, purely combinational.
// Latency : 0 cycles (combinational).
// Backpressure : none.
// Ports   : a_i/b_i operand chunks, cin_i carry-in, s_o chunk sum, cout_o carry-out.
module rca3
   import rca_seq_pkg::*;
(
   input  logic [CHUNK_W-1:0] a_i,
   input  logic [CHUNK_W-1:0] b_i,
   input  logic               cin_i,
   output logic [CHUNK_W-1:0] s_o,
   output logic               cout_o
);

   logic [CHUNK_W:0] c;

   assign c[0] = cin_i;

   for (genvar i = 0; i < CHUNK_W; i++) begin : g_fa
      assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = c[CHUNK_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Purpose : wide adder that time-multiplexes one rca3 over 3-bit chunks, LSB chunk first.
// Latency : NCHUNK cycles from accept to the one-cycle done pulse; back-to-back via start in DONE.
// Backpressure : start is taken only while ready (IDLE/DONE); start while busy is ignored.
// Ports   : clk, rst_n (async active-low), start/a/b/cin request, ready/busy/done status,
//           sum/cout result (held until next completion), ovf signed overflow.
// Config  : define RCA_SEQ_OVF_EN to add the ovf port and its register.
module rca_seq_ctrl
   import rca_seq_pkg::*;
#(
   parameter int NCHUNK = 4
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [CHUNK_W*NCHUNK-1:0] a,
   input  logic [CHUNK_W*NCHUNK-1:0] b,
   input  logic                    cin,
   output logic                    ready,
   output logic                    busy,
   output logic                    done,
   output logic [CHUNK_W*NCHUNK-1:0] sum,
   output logic                    cout
`ifdef RCA_SEQ_OVF_EN
   ,
   output logic                    ovf
`endif
);

   localparam int W  = CHUNK_W * NCHUNK;
   localparam int IW = idx_w(NCHUNK);
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   state_t           state_q;
   logic             ready_q, busy_q, done_q;
   logic [IW-1:0]    idx_q;
   logic             carry_q;
   logic [W-1:0]     a_q, b_q, work_q;
   logic [W-1:0]     sum_q;
   logic             cout_q;

   logic [CHUNK_W-1:0] a_chk, b_chk, s_chk;
   logic               s_cout;
   logic [W-1:0]       work_d;

   // Chunk mux: select the active operand chunk and merge the new sum chunk
   // into the work word. work_d is the completed sum on the final chunk.
   always_comb begin
      a_chk  = '0;
      b_chk  = '0;
      work_d = work_q;
      for (int k = 0; k < NCHUNK; k++) begin
         if (idx_q == IW'(k)) begin
            a_chk = a_q[CHUNK_W*k +: CHUNK_W];
            b_chk = b_q[CHUNK_W*k +: CHUNK_W];
            work_d[CHUNK_W*k +: CHUNK_W] = s_chk;
         end
      end
   end

   rca3 u_rca3 (
      .a_i    (a_chk),
      .b_i    (b_chk),
      .cin_i  (carry_q),
      .s_o    (s_chk),
      .cout_o (s_cout)
   );

`ifdef RCA_SEQ_OVF_EN
   logic ovf_q;
   logic ovf_d;
   assign ovf_d = (a_q[W-1] == b_q[W-1]) && (work_d[W-1] != a_q[W-1]);
   assign ovf   = ovf_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  idx_q   <= '0;
                  work_q  <= '0;
               end else begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            ST_RUN: begin
               work_q  <= work_d;
               carry_q <= s_cout;
               if (idx_q == LAST_IDX) begin
                  // Completion edge: publish result, index parks at zero.
                  state_q <= ST_DONE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  idx_q   <= '0;
                  sum_q   <= work_d;
                  cout_q  <= s_cout;
`ifdef RCA_SEQ_OVF_EN
                  ovf_q   <= ovf_d;
`endif
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign cout  = cout_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Purpose : directed self-checking bench for rca_seq_ctrl with NCHUNK=4 (12-bit operands).
// Latency : checks done arrives 4 cycles after accept.
// Backpressure : exercises start while busy and start in the DONE cycle.
module tb_rca_seq_ctrl;

   localparam int NCHUNK = 4;
   localparam int W      = 3 * NCHUNK;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         ready, busy, done, cout;
   logic [W-1:0] sum;
`ifdef RCA_SEQ_OVF_EN
   logic         ovf;
`endif

   int errors = 0;
   int checks = 0;

   rca_seq_ctrl #(.NCHUNK(NCHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef RCA_SEQ_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Stimulus only: request an op, then wait (bounded) for done.
   // Returns at the negedge inside the done cycle; lat = -1 on timeout.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, output int lat);
      @(negedge clk);
      start = 1'b1; a = ta; b = tb_; cin = tc;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 12 && lat < 0; i++) begin
         @(negedge clk);
         if (done === 1'b1) lat = i;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
      checks++; if (busy  !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done  !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (sum   !== 12'h000) begin errors++; $display("FAIL reset_sum got=%h exp=000", sum); end
      checks++; if (cout  !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
`ifdef RCA_SEQ_OVF_EN
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      int lat;
      run_op(12'h005, 12'h007, 1'b0, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
      checks++; if (sum !== 12'h00C) begin errors++; $display("FAIL basic_sum got=%h exp=00c", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b exp=0", cout); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready_in_done got=%b exp=1", ready); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
      checks++; if (sum !== 12'h00C) begin errors++; $display("FAIL basic_sum_hold got=%h exp=00c", sum); end
   endtask

   task automatic test_carry_ripple;
      int lat;
      run_op(12'hFFF, 12'h001, 1'b0, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
      checks++; if (sum !== 12'h000) begin errors++; $display("FAIL ripple_sum got=%h exp=000", sum); end
      checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ripple_cout got=%b exp=1", cout); end
   endtask

   task automatic test_back_to_back;
      int lat;
      run_op(12'hFFF, 12'hFFF, 1'b1, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=4", lat); end
      checks++; if (sum !== 12'hFFF) begin errors++; $display("FAIL b2b_first_sum got=%h exp=fff", sum); end
      checks++; if (cout !== 1'b1) begin errors++; $display("FAIL b2b_first_cout got=%b exp=1", cout); end
      // Still in the DONE cycle: request the next op right away.
      start = 1'b1; a = 12'h100; b = 12'h023; cin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_single got=%b exp=0", done); end
      lat = -1;
      for (int i = 1; i <= 12 && lat < 0; i++) begin
         @(negedge clk);
         if (done === 1'b1) lat = i;
         else if (sum !== 12'hFFF) begin
            checks++; errors++;
            $display("FAIL b2b_sum_midop got=%h exp=fff", sum);
         end
      end
      checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=4", lat); end
      checks++; if (sum !== 12'h123) begin errors++; $display("FAIL b2b_second_sum got=%h exp=123", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL b2b_second_cout got=%b exp=0", cout); end
   endtask

   task automatic test_busy_ignore;
      int ndone;
      logic [W-1:0] got;
      ndone = 0;
      got = '0;
      @(negedge clk);
      start = 1'b1; a = 12'h123; b = 12'h456; cin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin ndone++; got = sum; end
         if (i == 1) begin start = 1'b1; a = 12'hFFF; b = 12'hFFF; cin = 1'b1; end
         if (i == 2) begin start = 1'b1; a = 12'h000; b = 12'h001; cin = 1'b0; end
         if (i == 3) start = 1'b0;
      end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_done_count got=%0d exp=1", ndone); end
      checks++; if (got !== 12'h579) begin errors++; $display("FAIL busy_sum got=%h exp=579", got); end
      checks++; if (sum !== 12'h579) begin errors++; $display("FAIL busy_sum_hold got=%h exp=579", sum); end
   endtask

   task automatic test_reset_mid;
      int ndone;
      int lat;
      ndone = 0;
      @(negedge clk);
      start = 1'b1; a = 12'h0FF; b = 12'h001; cin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      // Now in the cycle where chunk 2 is being added.
      rst_n = 1'b0;
      #1;
      checks++; if (sum !== 12'h000) begin errors++; $display("FAIL midrst_sum got=%h exp=000", sum); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got=%b exp=0", cout); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
      run_op(12'h321, 12'h111, 1'b1, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
      checks++; if (sum !== 12'h433) begin errors++; $display("FAIL midrst_next_sum got=%h exp=433", sum); end
   endtask

`ifdef RCA_SEQ_OVF_EN
   task automatic test_ovf;
      int lat;
      run_op(12'h7FF, 12'h001, 1'b0, lat);
      checks++; if (sum !== 12'h800) begin errors++; $display("FAIL ovf_pos_sum got=%h exp=800", sum); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pos got=%b exp=1", ovf); end
      run_op(12'hFFF, 12'h001, 1'b0, lat);
      checks++; if (sum !== 12'h000) begin errors++; $display("FAIL ovf_neg_sum got=%h exp=000", sum); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_neg got=%b exp=0", ovf); end
   endtask
`endif

   initial begin
      test_reset;
      test_basic;
      test_carry_ripple;
      test_back_to_back;
      test_busy_ignore;
      test_reset_mid;
`ifdef RCA_SEQ_OVF_EN
      test_ovf;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rca_seq_ctrl.md
# rca_seq_ctrl

Sequencing controller that performs wide additions by time-multiplexing a single 3-bit ripple-carry adder (`rca3`) over operand chunks, least-significant chunk first. It latches two `3*NCHUNK`-bit operands and a carry-in on a start request. It then feeds one 3-bit chunk per clock through the adder, chaining the carry in a register, and presents the full sum and carry-out with a one-cycle `done` pulse. It sits between a requesting datapath and the shared `rca3` instance.

## Interface
- `NCHUNK`, 4: number of 3-bit chunks; operand width `W = 3*NCHUNK`; legal range 2..16.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `ready` is high.
- `a`  in  W  operand A; sampled with `start`.
- `b`  in  W  operand B; sampled with `start`.
- `cin`  in  1  carry-in to chunk 0; sampled with `start`.
- `ready`  out  1  high in IDLE and DONE (request can be accepted).
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse; `sum`/`cout` are valid and newly updated.
- `sum`  out  W  result; holds until the next completion.
- `cout`  out  1  carry out of the top chunk; holds like `sum`.
- `ovf`  out  1  signed overflow; present only with `RCA_SEQ_OVF_EN`.

## Operation
- Reset: state goes to IDLE. `ready`=1, `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0. All internal registers (chunk index, carry, operand and work registers) are cleared.
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → RUN while `idx < NCHUNK-1`.
  - RUN → DONE at `idx == NCHUNK-1`.
  - DONE → RUN on `start`; otherwise DONE → IDLE.
- Accept (`ready && start` at an edge):
  - Latch `a`, `b` into operand registers.
  - Load the carry register with `cin`.
  - Set `idx=0` and clear the work register.
- RUN, each cycle:
  - `rca3` inputs are `A=a_q[3*idx+:3]`, `B=b_q[3*idx+:3]`, `Cin=carry_q`.
  - At the edge, `work[3*idx+:3]` ← S, `carry_q` ← Cout, `idx` ← `idx+1`.
- On the edge leaving RUN: `sum` ← the completed work word, including the final chunk written that edge. `cout` ← final Cout. `done`=1 for exactly the DONE cycle.
- Arithmetic: `{cout,sum} = a + b + cin`, modulo `2^(W+1)`; unsigned. `sum`/`cout` change only on completion edges, never mid-operation.
- `start` while `busy`: ignored, with no effect on the in-flight operation or operands.
- `start` during DONE: accepted. That gives back-to-back operations with no idle cycle; `done` still pulses for one cycle.
- Reset mid-operation: the operation is aborted with no `done`, and outputs return to their reset values.
- Input changes on `a`/`b`/`cin` after acceptance have no effect.

## Timing
- Start accepted at edge t. Chunk k is written at edge t+1+k. DONE is entered at edge t+NCHUNK, so `done` is high in cycle [t+NCHUNK, t+NCHUNK+1).
- Latency is NCHUNK cycles from accept to `done`. Throughput is one operation per NCHUNK cycles when back-to-back.
- `ready`, `busy` and `done` are registered state decodes with no combinational path from `start`.
- The only combinational path is the 3-bit ripple through `rca3` plus the chunk mux, which is the critical path.

## Configuration
- `RCA_SEQ_OVF_EN` defined:
  - `ovf` port exists, with `ovf = (a_q[W-1]==b_q[W-1]) && (sum_next[W-1]!=a_q[W-1])`.
  - It is registered on the completion edge alongside `sum`, holds until the next completion, and resets to 0.
- `RCA_SEQ_OVF_EN` undefined: no `ovf` port and no associated logic; all other behaviour is identical.

## Structure
- Package `rca_seq_pkg`:
  - State encoding (IDLE=0, RUN=1, DONE=2, 2-bit).
  - `CHUNK_W=3`.
  - Index-width helper for `$clog2(NCHUNK)`.
- Sub-module: one `rca3` instance (3-bit ripple-carry adder built from three full adders), purely combinational. The controller contains the FSM, index counter, carry register, operand registers and result registers.

## Test plan
- NCHUNK=4, `a=12'h005`, `b=12'h007`, `cin=0` → `done` 4 cycles after accept, `sum=12'h00C`, `cout=0`.
- `a=12'hFFF`, `b=12'h001`, `cin=0` → `sum=12'h000`, `cout=1`; the carry ripples through all 4 chunks.
- `a=12'hFFF`, `b=12'hFFF`, `cin=1` → `sum=12'hFFF`, `cout=1`. Then `start` in the DONE cycle with `a=12'h100`, `b=12'h023` → second `done` 4 cycles later with `sum=12'h123`.
- `start` pulsed with new operands while `busy` → ignored; the original result is unchanged and `done` fires exactly once.
- `rst_n` low during RUN chunk 2 → no `done`; `sum=0`, `cout=0`, `ready=1`. The next operation is correct.
- With `RCA_SEQ_OVF_EN`: `12'h7FF+12'h001` → `ovf=1`, `sum=12'h800`. `12'hFFF+12'h001` → `ovf=0`.
